// File: rtl/st_align_unit.sv
// -----------------------------------------------------------------------------
// st_align_unit
//   Store alignment stage. It takes a core store request (byte address, raw rs2
//   data, store type) and turns it into word-aligned write beats for the data
//   memory: byte-lane write enables plus lane-shifted write data. Each beat is
//   registered toward memory behind a valid/ready handshake.
//
//   Optional feature macro: ST_MISALIGN_SPLIT_EN
//     defined   : a store crossing a word boundary is split into a low beat and
//                 a high beat (SEND -> SEND_HI); o_misalign_err stays low.
//     undefined : a crossing store is accepted and dropped, and o_misalign_err
//                 pulses for one cycle after acceptance.
//
// Ports:
//   i_clk          core clock, all state on the rising edge
//   i_rst          asynchronous active-high reset
//   i_req_valid    store request valid
//   o_req_ready    request accepted when i_req_valid && o_req_ready
//   i_req_stsel    store type: 0=sb, 1=sh, 2=sw, 3=sw
//   i_req_addr     byte address
//   i_req_data     rs2 value (low byte/half/word is stored)
//   o_mem_valid    write beat valid
//   i_mem_ready    memory accepts the beat when o_mem_valid && i_mem_ready
//   o_mem_addr     word-aligned beat address
//   o_mem_wdata    lane-shifted write data
//   o_mem_we       byte write enables, bit i covers wdata[8i+7:8i]
//   o_misalign_err one-cycle pulse for a dropped boundary-crossing store
//   o_busy         high while a beat is being presented
// -----------------------------------------------------------------------------
module st_align_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [1:0]            i_req_stsel,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [31:0]           i_req_data,
  output logic                  o_mem_valid,
  input  logic                  i_mem_ready,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [31:0]           o_mem_wdata,
  output logic [3:0]            o_mem_we,
  output logic                  o_misalign_err,
  output logic                  o_busy
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SEND    = 2'd1;
`ifdef ST_MISALIGN_SPLIT_EN
  localparam logic [1:0] ST_SEND_HI = 2'd2;
`endif

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;

  // Lane math for the request currently offered
  logic [1:0]            w_off;
  logic [7:0]            w_base_mask;
  logic [7:0]            w_mask8;
  logic [4:0]            w_shamt;
  logic                  w_cross;
  logic [ADDR_WIDTH-1:0] w_lo_addr;
  logic [31:0]           w_lo_wdata;

  // Handshake / control
  logic                  w_req_ready;
  logic                  w_mem_valid;
  logic                  w_accept;
  logic                  w_load_new;

  // Beat registers driving the memory port
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_we;
  logic [31:0]           r_wdata;
  logic                  r_misalign_err;

`ifdef ST_MISALIGN_SPLIT_EN
  logic [63:0]           w_data64;
  logic [ADDR_WIDTH-1:0] w_hi_addr;
  logic [31:0]           w_hi_wdata;
  logic [ADDR_WIDTH-1:0] r_hi_addr;
  logic [3:0]            r_hi_we;
  logic [31:0]           r_hi_wdata;
  logic                  r_split_pend;
`endif

  // Base byte mask for the store size (type 3 behaves as a word store)
  always_comb begin
    w_base_mask = 8'h0F;
    case (i_req_stsel)
      2'd0:    w_base_mask = 8'h01;
      2'd1:    w_base_mask = 8'h03;
      2'd2:    w_base_mask = 8'h0F;
      default: w_base_mask = 8'h0F;
    endcase
  end

  assign w_off     = i_req_addr[1:0];
  assign w_shamt   = {w_off, 3'b000};
  assign w_mask8   = w_base_mask << w_off;
  // Any enabled byte landing in the upper word means the store straddles words
  assign w_cross   = |w_mask8[7:4];
  assign w_lo_addr = {i_req_addr[ADDR_WIDTH-1:2], 2'b00};

`ifdef ST_MISALIGN_SPLIT_EN
  // Data is shifted unmasked; the enables pick the bytes actually written
  assign w_data64   = {32'h0000_0000, i_req_data} << w_shamt;
  assign w_lo_wdata = w_data64[31:0];
  assign w_hi_wdata = w_data64[63:32];
  assign w_hi_addr  = w_lo_addr + ADDR_WIDTH'(3'd4);
`else
  assign w_lo_wdata = i_req_data << w_shamt;
`endif

  assign w_accept = i_req_valid && w_req_ready;

`ifdef ST_MISALIGN_SPLIT_EN
  assign w_load_new = w_accept;
`else
  assign w_load_new = w_accept && !w_cross;
`endif

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; a fresh accept always wins over a completing beat
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_load_new) begin
          w_state_nxt = ST_SEND;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (w_load_new) begin
          w_state_nxt = ST_SEND;
`ifdef ST_MISALIGN_SPLIT_EN
        end else if (i_mem_ready && r_split_pend) begin
          w_state_nxt = ST_SEND_HI;
`endif
        end else if (i_mem_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_SEND;
        end
      end
`ifdef ST_MISALIGN_SPLIT_EN
      ST_SEND_HI: begin
        if (i_mem_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_SEND_HI;
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs; in SEND a new request is taken only when the beat drains now
  always_comb begin
    w_req_ready = 1'b0;
    w_mem_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_req_ready = 1'b1;
        w_mem_valid = 1'b0;
      end
      ST_SEND: begin
        w_mem_valid = 1'b1;
`ifdef ST_MISALIGN_SPLIT_EN
        w_req_ready = i_mem_ready && !r_split_pend;
`else
        w_req_ready = i_mem_ready;
`endif
      end
`ifdef ST_MISALIGN_SPLIT_EN
      ST_SEND_HI: begin
        w_req_ready = 1'b0;
        w_mem_valid = 1'b1;
      end
`endif
      default: begin
        w_req_ready = 1'b0;
        w_mem_valid = 1'b0;
      end
    endcase
  end

  // Beat registers: load new beat, advance to high beat, or clear enables on idle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr         <= '0;
      r_we           <= 4'b0000;
      r_wdata        <= 32'h0000_0000;
      r_misalign_err <= 1'b0;
`ifdef ST_MISALIGN_SPLIT_EN
      r_hi_addr      <= '0;
      r_hi_we        <= 4'b0000;
      r_hi_wdata     <= 32'h0000_0000;
      r_split_pend   <= 1'b0;
`endif
    end else begin
`ifdef ST_MISALIGN_SPLIT_EN
      r_misalign_err <= 1'b0;
`else
      r_misalign_err <= w_accept && w_cross;
`endif
      if (w_load_new) begin
        r_addr       <= w_lo_addr;
        r_we         <= w_mask8[3:0];
        r_wdata      <= w_lo_wdata;
`ifdef ST_MISALIGN_SPLIT_EN
        r_hi_addr    <= w_hi_addr;
        r_hi_we      <= w_mask8[7:4];
        r_hi_wdata   <= w_hi_wdata;
        r_split_pend <= w_cross;
      end else if ((r_state == ST_SEND) && i_mem_ready && r_split_pend) begin
        r_addr       <= r_hi_addr;
        r_we         <= r_hi_we;
        r_wdata      <= r_hi_wdata;
        r_split_pend <= 1'b0;
`endif
      end else if (w_state_nxt == ST_IDLE) begin
        // Keeps enables at zero whenever no beat is presented
        r_we <= 4'b0000;
      end
    end
  end

  assign o_req_ready    = w_req_ready;
  assign o_mem_valid    = w_mem_valid;
  assign o_mem_addr     = r_addr;
  assign o_mem_wdata    = r_wdata;
  assign o_mem_we       = r_we;
  assign o_misalign_err = r_misalign_err;
  assign o_busy         = (r_state != ST_IDLE);

endmodule
